// File: rtl/trace_pkg.sv
// Shared types for the instruction-trace capture block: FSM encoding,
// entry kind codes and the packed entry width.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // Entry layout, MSB first: {kind, pc, addr, data}
    function automatic int entry_w(input int pc_w, input int data_w);
        return 1 + pc_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Simple dual-port storage for trace entries: one write port and one
// registered read port. Contents are not reset.
import trace_pkg::*;

module trace_fifo_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Read returns the pre-write contents on an address collision.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_capture.sv
// Retirement trace capture: records register and memory writes into a
// show-ahead FIFO with stop-when-full or overwrite-oldest policy.
import trace_pkg::*;

module trace_capture #(
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [PC_W-1:0]            pc_i,
    input  logic                       rf_we_i,
    input  logic [4:0]                 rf_addr_i,
    input  logic [DATA_W-1:0]          rf_data_i,
    input  logic                       dm_we_i,
    input  logic [DATA_W-1:0]          dm_addr_i,
    input  logic [DATA_W-1:0]          dm_data_i,
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic                       rd_kind_o,
    output logic [PC_W-1:0]            rd_pc_o,
    output logic [DATA_W-1:0]          rd_addr_o,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       collision_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = entry_w(PC_W, DATA_W);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        r_state;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf, r_col;
    logic          r_byp;
    logic [EW-1:0] r_byp_data;

    logic          w_cap, w_ev_mem, w_ev, w_pop, w_full;
    logic          w_push_ok, w_overwrite, w_wr_en, w_lost;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [AW:0]   w_count_nxt;
    logic [EW-1:0] w_entry, w_mem_q, w_head;

    assign w_cap       = (r_state == ST_CAPTURE);
    assign w_ev_mem    = dm_we_i;
    assign w_ev        = dm_we_i | (rf_we_i & (rf_addr_i != 5'd0));
    assign w_pop       = (r_count != '0) & rd_ready_i;
    assign w_full      = (r_count == FULL_CNT);
    assign w_push_ok   = w_cap & w_ev & (~w_full | w_pop);
    assign w_overwrite = w_cap & w_ev & w_full & ~w_pop & (WRAP_MODE == 1);
    assign w_wr_en     = w_push_ok | w_overwrite;
    assign w_lost      = (w_cap & w_ev & w_full & ~w_pop) | ((r_state == ST_HALTED) & w_ev);
    assign w_rd_ptr_nxt = (w_pop | w_overwrite) ? r_rd_ptr + AW'(1) : r_rd_ptr;

    // Memory entry wins a collision; the register write is dropped.
    assign w_entry = w_ev_mem ? {KIND_MEM, pc_i, dm_addr_i, dm_data_i}
                              : {KIND_REG, pc_i, DATA_W'(rf_addr_i), rf_data_i};

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop)      w_count_nxt = r_count + (AW+1)'(1);
        else if (!w_push_ok && w_pop) w_count_nxt = r_count - (AW+1)'(1);
    end

    // The read port always fetches the next head; a same-edge write to that
    // slot is forwarded through r_byp so a lone entry appears without a bubble.
    trace_fifo_mem #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .i_clk   (clk_i),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_entry),
        .i_raddr (w_rd_ptr_nxt),
        .o_rdata (w_mem_q)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_col      <= 1'b0;
            r_byp      <= 1'b1;
            r_byp_data <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_lost) r_ovf <= 1'b1;
            if (w_cap && rf_we_i && dm_we_i) r_col <= 1'b1;
            // Forwarded head is held while empty so idle outputs stay quiet.
            if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) begin
                r_byp      <= 1'b1;
                r_byp_data <= w_entry;
            end else if (w_count_nxt != '0) begin
                r_byp <= 1'b0;
            end
            case (r_state)
                ST_IDLE:    if (enable_i) r_state <= ST_CAPTURE;
                ST_CAPTURE: if (!enable_i) r_state <= ST_IDLE;
                            else if (WRAP_MODE == 0 && w_count_nxt == FULL_CNT) r_state <= ST_HALTED;
                ST_HALTED:  if (!enable_i) r_state <= ST_IDLE;
                            else if (r_count < FULL_CNT) r_state <= ST_CAPTURE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_head      = r_byp ? r_byp_data : w_mem_q;
    assign rd_valid_o  = (r_count != '0);
    assign rd_kind_o   = w_head[EW-1];
    assign rd_pc_o     = w_head[EW-2 -: PC_W];
    assign rd_addr_o   = w_head[2*DATA_W-1 -: DATA_W];
    assign rd_data_o   = w_head[DATA_W-1:0];
    assign count_o     = r_count;
    assign overflow_o  = r_ovf;
    assign collision_o = r_col;

endmodule
